// File: rtl/fb_writer.sv
// Pixel framebuffer writer: queues raster pixels, writes them to SRAM,
// and can sweep the whole framebuffer with CLEAR_COLOR on request.
module fb_writer #(
    parameter int                 COLOR_W     = 16,
    parameter int                 X_BITS      = 10,
    parameter int                 Y_BITS      = 9,
    parameter int                 FB_WIDTH    = 1024,
    parameter int                 FB_HEIGHT   = 512,
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_in,
    output logic                     rdy_in,
    input  logic [COLOR_W-1:0]       color_in,
    input  logic [X_BITS-1:0]        pix_x,
    input  logic [Y_BITS-1:0]        pix_y,
    input  logic                     clr_start,
    output logic                     fb_we,
    input  logic                     fb_gnt,
    output logic [X_BITS+Y_BITS-1:0] fb_addr,
    output logic [COLOR_W-1:0]       fb_wdata,
    output logic                     busy,
    output logic                     clr_done,
    output logic [31:0]              pix_count,
    output logic [15:0]              drop_count
);

    localparam int AW = X_BITS + Y_BITS;
    localparam int EW = AW + COLOR_W;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] LAST = AW'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_CLEAR} state_e;

    state_e             state_q, state_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d, head_idx;
    logic [CW-1:0]      cnt_q, cnt_d, avail;
    logic               we_q, we_d, done_q, done_d;
    logic [AW-1:0]      addr_q, addr_d, addr_calc;
    logic [COLOR_W-1:0] wdata_q, wdata_d;
    logic [31:0]        pix_q, pix_d;
    logic [15:0]        drop_q, drop_d;
    logic               in_rng, full, rdy, acc, push, pop, drop_inc;

    // Handshakes, FIFO bookkeeping, output staging and the clear sweep.
    always_comb begin
        addr_calc = AW'(pix_y) * AW'(FB_WIDTH) + AW'(pix_x);
        in_rng    = (32'(pix_x) < 32'(FB_WIDTH)) && (32'(pix_y) < 32'(FB_HEIGHT));
        full      = (cnt_q == CW'(FIFO_DEPTH));
        rdy       = rst_n && (state_q == S_RUN) && !full;
        acc       = vld_in && rdy;
        push      = acc && in_rng;
        pop       = we_q && fb_gnt && (state_q != S_CLEAR);
        drop_inc  = acc && !in_rng && (drop_q != 16'hFFFF);
        head_idx  = rp_q + PW'(pop);
        avail     = cnt_q - CW'(pop);

        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        wp_d    = wp_q + PW'(push);
        rp_d    = rp_q + PW'(pop);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        pix_d   = pix_q + 32'(pop);
        drop_d  = drop_q + 16'(drop_inc);

        unique case (state_q)
            S_RUN, S_DRAIN: begin
                if (!we_q || fb_gnt) begin
                    we_d = (avail != '0);
                    if (avail != '0) begin
                        {addr_d, wdata_d} = mem_q[head_idx];
                    end
                end
                if (state_q == S_RUN && clr_start) begin
                    state_d = S_DRAIN;
                end
                if (state_q == S_DRAIN && cnt_q == '0 && !we_q) begin
                    state_d = S_CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = CLEAR_COLOR;
                end
            end
            S_CLEAR: begin
                if (fb_gnt) begin
                    if (addr_q == LAST) begin
                        we_d    = 1'b0;
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Pixel storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= {addr_calc, color_in};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            pix_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
            drop_q  <= drop_d;
        end
    end

    assign rdy_in     = rdy;
    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_wdata   = wdata_q;
    assign busy       = (cnt_q != '0) || (state_q != S_RUN);
    assign clr_done   = done_q;
    assign pix_count  = pix_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer on a 16x16 framebuffer:
// cycle table for the pixel path, hand sequences for clears and reset.
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_in = 1'b0;
    logic        rdy_in;
    logic [7:0]  color_in = '0;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        clr_start = 1'b0;
    logic        fb_we;
    logic        fb_gnt = 1'b0;
    logic [18:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        clr_done;
    logic [31:0] pix_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_writer #(
        .COLOR_W(8), .X_BITS(10), .Y_BITS(9),
        .FB_WIDTH(16), .FB_HEIGHT(16), .FIFO_DEPTH(4),
        .CLEAR_COLOR(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vld_in(vld_in), .rdy_in(rdy_in),
        .color_in(color_in), .pix_x(pix_x), .pix_y(pix_y),
        .clr_start(clr_start),
        .fb_we(fb_we), .fb_gnt(fb_gnt),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .busy(busy), .clr_done(clr_done),
        .pix_count(pix_count), .drop_count(drop_count)
    );

    typedef struct {
        logic vld; int x; int y; int c; logic gnt;
        logic rdy; logic we; int addr; int data; int pix; int drop;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic vld, int x, int y, int c, logic gnt,
                                logic rdy, logic we, int addr, int data,
                                int pix, int drop);
        vec_t r;
        r.vld = vld; r.x = x; r.y = y; r.c = c; r.gnt = gnt;
        r.rdy = rdy; r.we = we; r.addr = addr; r.data = data;
        r.pix = pix; r.drop = drop;
        return r;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waddr[300];
        int wdat[300];
        int nw, bad, done_at, last_w, unstable;
        int seen[256];
        logic [18:0] prev_addr;
        logic prev_stall;

        // vld x y c gnt | rdy we addr data pix drop
        v[0]  = mk(1, 1, 1, 'h04, 1,  1, 0, 0, 0, 0, 0);
        v[1]  = mk(0, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0);
        v[2]  = mk(0, 0, 0, 0, 1,     1, 1, 17, 'h04, 0, 0);
        v[3]  = mk(0, 0, 0, 0, 1,     1, 0, 0, 0, 1, 0);
        v[4]  = mk(1, 2, 0, 'h11, 0,  1, 0, 0, 0, 1, 0);
        v[5]  = mk(1, 3, 0, 'h12, 0,  1, 0, 0, 0, 1, 0);
        v[6]  = mk(1, 0, 2, 'h13, 0,  1, 1, 2, 'h11, 1, 0);
        v[7]  = mk(1, 15, 15, 'h14, 0, 1, 1, 2, 'h11, 1, 0);
        v[8]  = mk(1, 5, 5, 'h15, 0,  0, 1, 2, 'h11, 1, 0);
        v[9]  = mk(1, 5, 5, 'h15, 1,  0, 1, 2, 'h11, 1, 0);
        v[10] = mk(1, 5, 5, 'h15, 1,  1, 1, 3, 'h12, 2, 0);
        v[11] = mk(0, 0, 0, 0, 1,     1, 1, 32, 'h13, 3, 0);
        v[12] = mk(0, 0, 0, 0, 1,     1, 1, 255, 'h14, 4, 0);
        v[13] = mk(0, 0, 0, 0, 1,     1, 1, 85, 'h15, 5, 0);
        v[14] = mk(0, 0, 0, 0, 1,     1, 0, 0, 0, 6, 0);
        v[15] = mk(1, 16, 0, 'h20, 1, 1, 0, 0, 0, 6, 0);
        v[16] = mk(1, 0, 16, 'h21, 1, 1, 0, 0, 0, 6, 1);
        v[17] = mk(0, 0, 0, 0, 1,     1, 0, 0, 0, 6, 2);
        v[18] = mk(0, 0, 0, 0, 1,     1, 0, 0, 0, 6, 2);

        // Reset state
        rst_n = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_rdy", rdy_in, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_wdata, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_pix", pix_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", busy, 0);
        next_cycle();
        rst_n = 1'b1;

        // Pixel path cycle table
        for (int i = 0; i < 19; i++) begin
            vld_in   = v[i].vld;
            pix_x    = 10'(v[i].x);
            pix_y    = 9'(v[i].y);
            color_in = 8'(v[i].c);
            fb_gnt   = v[i].gnt;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), rdy_in, v[i].rdy);
            chk($sformatf("v%0d_we", i), fb_we, v[i].we);
            if (v[i].we) begin
                chk($sformatf("v%0d_addr", i), fb_addr, v[i].addr);
                chk($sformatf("v%0d_data", i), fb_wdata, v[i].data);
            end
            chk($sformatf("v%0d_pix", i), pix_count, v[i].pix);
            chk($sformatf("v%0d_drop", i), drop_count, v[i].drop);
            next_cycle();
        end
        vld_in = 1'b0;

        // Queued pixels ahead of a clear; clr_start with an accept
        fb_gnt = 1'b0;
        vld_in = 1'b1; pix_x = 10'd4; pix_y = 9'd0; color_in = 8'h31;
        next_cycle();
        pix_x = 10'd5; color_in = 8'h32; clr_start = 1'b1;
        @(negedge clk);
        chk("a_acc_rdy", rdy_in, 1);
        next_cycle();
        vld_in = 1'b0; clr_start = 1'b0;
        @(negedge clk);
        chk("a_drain_rdy", rdy_in, 0);
        chk("a_drain_busy", busy, 1);
        next_cycle();
        fb_gnt = 1'b1;
        nw = 0; done_at = -1; last_w = -1;
        for (int cyc = 0; cyc < 1000 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (clr_done) done_at = cyc;
            if (fb_we && fb_gnt && nw < 300) begin
                waddr[nw] = int'(fb_addr);
                wdat[nw]  = int'(fb_wdata);
                nw++;
                last_w = cyc;
            end
            next_cycle();
        end
        chk("a_done_seen", done_at >= 0, 1);
        chk("a_nwrites", nw, 258);
        chk("a_w0_addr", waddr[0], 4);
        chk("a_w0_data", wdat[0], 'h31);
        chk("a_w1_addr", waddr[1], 5);
        chk("a_w1_data", wdat[1], 'h32);
        bad = 0;
        for (int i = 2; i < nw; i++) begin
            if (waddr[i] != i - 2 || wdat[i] != 0) bad++;
        end
        chk("a_clear_seq", bad, 0);
        chk("a_done_timing", done_at, last_w + 1);
        @(negedge clk);
        chk("a_done_pulse", clr_done, 0);
        chk("a_busy_after", busy, 0);
        chk("a_we_after", fb_we, 0);
        chk("a_rdy_after", rdy_in, 1);
        chk("a_pix_after", pix_count, 8);
        chk("a_drop_after", drop_count, 2);
        next_cycle();

        // Clear under toggling grant; stray clr_start mid-sweep
        fb_gnt = 1'b0;
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 0;
        nw = 0; bad = 0; done_at = -1; unstable = 0;
        prev_stall = 1'b0; prev_addr = '0;
        for (int cyc = 0; cyc < 2000 && done_at < 0; cyc++) begin
            fb_gnt    = (cyc % 2 == 0);
            clr_start = (cyc == 50);
            @(negedge clk);
            if (clr_done) done_at = cyc;
            if (prev_stall && fb_addr != prev_addr) unstable++;
            if (fb_we && fb_gnt) begin
                if (fb_addr < 19'd256) seen[fb_addr[7:0]]++;
                else bad++;
                nw++;
            end
            prev_stall = fb_we && !fb_gnt;
            prev_addr  = fb_addr;
            next_cycle();
        end
        clr_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (seen[i] != 1) bad++;
        end
        chk("b_done_seen", done_at >= 0, 1);
        chk("b_nwrites", nw, 256);
        chk("b_each_once", bad, 0);
        chk("b_stall_hold", unstable, 0);
        chk("b_pix_same", pix_count, 8);
        @(negedge clk);
        chk("b_busy_after", busy, 0);
        next_cycle();

        // Reset in the middle of a clear
        fb_gnt = 1'b1;
        clr_start = 1'b1;
        next_cycle();
        clr_start = 1'b0;
        repeat (20) next_cycle();
        @(negedge clk);
        chk("c_mid_busy", busy, 1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("c_rst_we", fb_we, 0);
        chk("c_rst_busy", busy, 0);
        chk("c_rst_pix", pix_count, 0);
        chk("c_rst_drop", drop_count, 0);
        chk("c_rst_done", clr_done, 0);
        chk("c_rst_rdy", rdy_in, 0);
        next_cycle();
        rst_n = 1'b1;
        vld_in = 1'b1; pix_x = 10'd3; pix_y = 9'd3; color_in = 8'h44;
        @(negedge clk);
        chk("c_new_rdy", rdy_in, 1);
        next_cycle();
        vld_in = 1'b0;
        @(negedge clk);
        chk("c_new_we0", fb_we, 0);
        next_cycle();
        @(negedge clk);
        chk("c_new_we1", fb_we, 1);
        chk("c_new_addr", fb_addr, 51);
        chk("c_new_data", fb_wdata, 'h44);
        next_cycle();
        @(negedge clk);
        chk("c_new_pix", pix_count, 1);
        chk("c_new_we_off", fb_we, 0);
        chk("c_new_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
